// File: rtl/uart_tx_feeder.sv
// Buffered UART transmit front end: a circular byte FIFO feeding a launch
// sequencer that paces one tx_start pulse per frame against tx_busy.
module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clear_ovf,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, empty_q, overflow_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  wr_accept, pop;

    // Full is the registered flag, so a pop in the same cycle cannot rescue a write.
    assign wr_accept = wr_en && !full_q;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q && !tx_busy) begin
                    pop     = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH:    state_d = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign count_d = count_q + {{ADDR_WIDTH{1'b0}}, wr_accept}
                             - {{ADDR_WIDTH{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= (count_d == FULL_COUNT);
            empty_q <= (count_d == '0);
            if (wr_accept) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + ADDR_WIDTH'(1);
                tx_data_q <= mem[rd_ptr_q];
            end
            // A dropped write outranks a simultaneous clear.
            if (wr_en && full_q) overflow_q <= 1'b1;
            else if (clear_ovf)  overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr_q] <= wr_data;
    end

    assign tx_start = (state_q == LAUNCH);
    assign tx_data  = tx_data_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
